// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: MemOp codes, FSM state
// encoding and the default address/data widths of data_mem.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    // MemOp encodings as understood by data_mem (stores reuse OP_B/OP_H/OP_W)
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b011;
    localparam logic [2:0] OP_HU = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input arbiter decision logic. Purely combinational: the priority
// pointer is owned by the caller, so this block only picks the winner.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    input  logic fixed_prio,
    output logic win_idx,
    output logic win_vld
);

    // Pick the winning port from the request pair, pointer and priority mode
    always_comb begin
        win_idx = 1'b0;
        win_vld = 1'b0;
        case ({req1, req0})
            2'b01: begin
                win_idx = 1'b0;
                win_vld = 1'b1;
            end
            2'b10: begin
                win_idx = 1'b1;
                win_vld = 1'b1;
            end
            2'b11: begin
                win_vld = 1'b1;
                if (fixed_prio) begin
                    win_idx = 1'b0;
                end else begin
                    win_idx = ptr;
                end
            end
            default: begin
                win_idx = 1'b0;
                win_vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_mem load/store port between the CPU memory stage
// (port 0) and the UART loader / debug master (port 1). One access cycle per
// grant; every output toward the masters and data_mem comes from a flop.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_op,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_op,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_DataIn,
    output logic [2:0]        mem_MemOp,
    output logic              mem_MemWr,
    input  logic [DATA_W-1:0] mem_DataOut
);

    localparam logic FIXED_S = (FIXED_PRIO != 0) ? 1'b1 : 1'b0;

    arb_state_e        state_r, state_nx_s;
    logic              ptr_r, ptr_nx_s;
    logic              win_idx_s, win_vld_s;

    logic              owner_r, owner_nx_s;
    logic              gnt0_r, gnt0_nx_s, gnt1_r, gnt1_nx_s;
    logic              done0_r, done0_nx_s, done1_r, done1_nx_s;
    logic [DATA_W-1:0] rdata0_r, rdata0_nx_s, rdata1_r, rdata1_nx_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nx_s;
    logic [DATA_W-1:0] mem_din_r, mem_din_nx_s;
    logic [2:0]        mem_op_r, mem_op_nx_s;
    logic              mem_wr_r, mem_wr_nx_s;

    rr_arb2 u_rr_arb2 (
        .req0       (m0_req),
        .req1       (m1_req),
        .ptr        (ptr_r),
        .fixed_prio (FIXED_S),
        .win_idx    (win_idx_s),
        .win_vld    (win_vld_s)
    );

    // State and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
        end
    end

    // Next-state and pointer update; the pointer only moves on a contested win
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_nx_s = ST_ACCESS;
                    if (m0_req && m1_req && !FIXED_S) begin
                        ptr_nx_s = ~win_idx_s;
                    end else begin
                        ptr_nx_s = ptr_r;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the output flops: launch an access, then complete it
    always_comb begin
        owner_nx_s    = owner_r;
        gnt0_nx_s     = 1'b0;
        gnt1_nx_s     = 1'b0;
        done0_nx_s    = 1'b0;
        done1_nx_s    = 1'b0;
        rdata0_nx_s   = rdata0_r;
        rdata1_nx_s   = rdata1_r;
        mem_addr_nx_s = mem_addr_r;
        mem_din_nx_s  = mem_din_r;
        mem_op_nx_s   = mem_op_r;
        mem_wr_nx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    owner_nx_s = win_idx_s;
                    if (win_idx_s) begin
                        gnt1_nx_s     = 1'b1;
                        mem_addr_nx_s = m1_addr;
                        mem_din_nx_s  = m1_wdata;
                        mem_op_nx_s   = m1_op;
                        mem_wr_nx_s   = m1_we;
                    end else begin
                        gnt0_nx_s     = 1'b1;
                        mem_addr_nx_s = m0_addr;
                        mem_din_nx_s  = m0_wdata;
                        mem_op_nx_s   = m0_op;
                        mem_wr_nx_s   = m0_we;
                    end
                end else begin
                    owner_nx_s = owner_r;
                end
            end
            ST_ACCESS: begin
                // mem_wr_r holds the latched direction for the whole access
                if (owner_r) begin
                    done1_nx_s = 1'b1;
                    if (!mem_wr_r) begin
                        rdata1_nx_s = mem_DataOut;
                    end else begin
                        rdata1_nx_s = rdata1_r;
                    end
                end else begin
                    done0_nx_s = 1'b1;
                    if (!mem_wr_r) begin
                        rdata0_nx_s = mem_DataOut;
                    end else begin
                        rdata0_nx_s = rdata0_r;
                    end
                end
            end
            default: begin
                owner_nx_s = owner_r;
            end
        endcase
    end

    // Output flops; reset clears MemWr asynchronously so a pending store aborts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r    <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            rdata0_r   <= {DATA_W{1'b0}};
            rdata1_r   <= {DATA_W{1'b0}};
            mem_addr_r <= {ADDR_W{1'b0}};
            mem_din_r  <= {DATA_W{1'b0}};
            mem_op_r   <= 3'b000;
            mem_wr_r   <= 1'b0;
        end else begin
            owner_r    <= owner_nx_s;
            gnt0_r     <= gnt0_nx_s;
            gnt1_r     <= gnt1_nx_s;
            done0_r    <= done0_nx_s;
            done1_r    <= done1_nx_s;
            rdata0_r   <= rdata0_nx_s;
            rdata1_r   <= rdata1_nx_s;
            mem_addr_r <= mem_addr_nx_s;
            mem_din_r  <= mem_din_nx_s;
            mem_op_r   <= mem_op_nx_s;
            mem_wr_r   <= mem_wr_nx_s;
        end
    end

    assign m0_gnt     = gnt0_r;
    assign m1_gnt     = gnt1_r;
    assign m0_done    = done0_r;
    assign m1_done    = done1_r;
    assign m0_rdata   = rdata0_r;
    assign m1_rdata   = rdata1_r;
    assign mem_Addr   = mem_addr_r;
    assign mem_DataIn = mem_din_r;
    assign mem_MemOp  = mem_op_r;
    assign mem_MemWr  = mem_wr_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter. Two instances: index 0 round-robin,
// index 1 fixed priority, each with its own data_mem model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         m0_req, m0_we, m1_req, m1_we;
    logic [1:0][AW-1:0] m0_addr, m1_addr;
    logic [1:0][DW-1:0] m0_wdata, m1_wdata;
    logic [1:0][2:0]    m0_op, m1_op;
    logic [1:0]         m0_gnt, m0_done, m1_gnt, m1_done;
    logic [1:0][DW-1:0] m0_rdata, m1_rdata;
    logic [1:0][AW-1:0] mem_Addr;
    logic [1:0][DW-1:0] mem_DataIn, mem_DataOut;
    logic [1:0][2:0]    mem_MemOp;
    logic [1:0]         mem_MemWr;

    logic [31:0] mem [2][1024];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t        sb_q [4][$];
    int          gq   [2][$];
    logic [31:0] held [4];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .m0_req      (m0_req[g]),
            .m0_we       (m0_we[g]),
            .m0_addr     (m0_addr[g]),
            .m0_wdata    (m0_wdata[g]),
            .m0_op       (m0_op[g]),
            .m1_req      (m1_req[g]),
            .m1_we       (m1_we[g]),
            .m1_addr     (m1_addr[g]),
            .m1_wdata    (m1_wdata[g]),
            .m1_op       (m1_op[g]),
            .m0_gnt      (m0_gnt[g]),
            .m0_done     (m0_done[g]),
            .m0_rdata    (m0_rdata[g]),
            .m1_gnt      (m1_gnt[g]),
            .m1_done     (m1_done[g]),
            .m1_rdata    (m1_rdata[g]),
            .mem_Addr    (mem_Addr[g]),
            .mem_DataIn  (mem_DataIn[g]),
            .mem_MemOp   (mem_MemOp[g]),
            .mem_MemWr   (mem_MemWr[g]),
            .mem_DataOut (mem_DataOut[g])
        );
    end

    // data_mem model: combinational word read, store committed at the clock edge
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mem_DataOut[d] = mem[d][mem_Addr[d][11:2]];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (mem_MemWr[d]) begin
                logic [31:0] w;
                logic [11:0] a;
                a = mem_Addr[d];
                w = mem[d][a[11:2]];
                case (mem_MemOp[d])
                    OP_B:    w[8*a[1:0] +: 8]  = mem_DataIn[d][7:0];
                    OP_H:    w[16*a[1] +: 16]  = mem_DataIn[d][15:0];
                    default: w                 = mem_DataIn[d];
                endcase
                mem[d][a[11:2]] <= w;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a grant or done is presented
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                logic [1:0] gn, dn;
                gn = {m1_gnt[d], m0_gnt[d]};
                dn = {m1_done[d], m0_done[d]};
                if (gn != 2'b00) begin
                    chk($sformatf("dual_gnt[%0d]", d), {31'd0, &gn}, 32'd0);
                    if (gq[d].size() == 0) begin
                        chk($sformatf("unexpected_gnt[%0d]", d), {30'd0, gn}, 32'd0);
                    end else begin
                        chk($sformatf("gnt_owner[%0d]", d), {31'd0, gn[1]}, 32'(gq[d].pop_front()));
                    end
                end
                if (dn != 2'b00) begin
                    chk($sformatf("dual_done[%0d]", d), {31'd0, &dn}, 32'd0);
                end
                for (int p = 0; p < 2; p++) begin
                    if (dn[p]) begin
                        if (sb_q[d*2+p].size() == 0) begin
                            chk($sformatf("unexpected_done[%0d].m%0d", d, p), 32'd1, 32'd0);
                        end else begin
                            exp_t e;
                            e = sb_q[d*2+p].pop_front();
                            chk($sformatf("rdata[%0d].m%0d", d, p),
                                (p == 0) ? m0_rdata[d] : m1_rdata[d], e.rdata);
                            if (e.cyc >= 0) begin
                                chk($sformatf("done_cycle[%0d].m%0d", d, p), 32'(cyc), 32'(e.cyc));
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic set_port(input int d, input int p, input logic req, input logic we,
                            input logic [11:0] a, input logic [31:0] wd, input logic [2:0] op);
        if (p == 0) begin
            m0_req[d] = req; m0_we[d] = we; m0_addr[d] = a; m0_wdata[d] = wd; m0_op[d] = op;
        end else begin
            m1_req[d] = req; m1_we[d] = we; m1_addr[d] = a; m1_wdata[d] = wd; m1_op[d] = op;
        end
    endtask

    task automatic drop_req(input int d, input int p);
        if (p == 0) m0_req[d] = 1'b0;
        else        m1_req[d] = 1'b0;
    endtask

    // Wait (bounded) for the port's grant; returns at the negedge inside ACCESS
    task automatic wait_gnt(input int d, input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((p == 0) ? m0_gnt[d] : m1_gnt[d]) seen = 1'b1;
        end
        if (!seen) chk($sformatf("gnt_timeout[%0d].m%0d", d, p), 32'd0, 32'd1);
    endtask

    // One transaction on one port, with its expected response queued first
    task automatic issue(input int d, input int p, input logic we, input logic [11:0] a,
                         input logic [31:0] wd, input logic [2:0] op, input logic [31:0] exp_rd);
        exp_t e;
        if (!we) held[d*2+p] = exp_rd;
        e.rdata = held[d*2+p];
        e.cyc   = cyc + 2;
        sb_q[d*2+p].push_back(e);
        gq[d].push_back(p);
        set_port(d, p, 1'b1, we, a, wd, op);
        wait_gnt(d, p);
        drop_req(d, p);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Both ports load continuously, two accesses each
    task automatic both_test(input int d);
        int n0, n1;
        exp_t e0, e1;
        int order [4];
        if (d == 0) order = '{0, 1, 0, 1};
        else        order = '{0, 0, 1, 1};
        held[d*2]   = 32'hDEADBEEF;
        held[d*2+1] = 32'h12345678;
        e0.rdata = held[d*2];   e0.cyc = -1;
        e1.rdata = held[d*2+1]; e1.cyc = -1;
        for (int k = 0; k < 4; k++) gq[d].push_back(order[k]);
        for (int k = 0; k < 2; k++) begin
            sb_q[d*2].push_back(e0);
            sb_q[d*2+1].push_back(e1);
        end
        n0 = 0; n1 = 0;
        set_port(d, 0, 1'b1, 1'b0, 12'h000, 32'h0, OP_W);
        set_port(d, 1, 1'b1, 1'b0, 12'h004, 32'h0, OP_W);
        for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
            @(negedge clk);
            if (m0_gnt[d]) begin n0++; if (n0 == 2) drop_req(d, 0); end
            if (m1_gnt[d]) begin n1++; if (n1 == 2) drop_req(d, 1); end
        end
        chk($sformatf("both_grants[%0d]", d), 32'(n0 * 10 + n1), 32'd22);
        drop_req(d, 0);
        drop_req(d, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    int mw_cnt = 0;
    always @(negedge clk) if (mem_MemWr[0]) mw_cnt <= mw_cnt + 1;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) mem[d][i] = 32'h0;
            set_port(d, 0, 1'b0, 1'b0, 12'h0, 32'h0, 3'b000);
            set_port(d, 1, 1'b0, 1'b0, 12'h0, 32'h0, 3'b000);
        end
        mem[0][1] = 32'h12345678;
        mem[1][0] = 32'hDEADBEEF;
        mem[1][1] = 32'h12345678;
        for (int i = 0; i < 4; i++) held[i] = 32'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_mem_Addr[%0d]", d), 32'(mem_Addr[d]), 32'd0);
            chk($sformatf("rst_mem_DataIn[%0d]", d), mem_DataIn[d], 32'd0);
            chk($sformatf("rst_ctrl[%0d]", d),
                {22'd0, mem_MemOp[d], mem_MemWr[d], m0_gnt[d], m1_gnt[d], m0_done[d], m1_done[d]}, 32'd0);
            chk($sformatf("rst_rdata[%0d]", d), m0_rdata[d] | m1_rdata[d], 32'd0);
        end

        // Port 0 store, then port 1 load of the same word
        mw_cnt = 0;
        issue(0, 0, 1'b1, 12'h000, 32'hDEADBEEF, OP_W, 32'h0);
        chk("sw_memwr_cycles", 32'(mw_cnt), 32'd1);
        chk("sw_mem_word", mem[0][0], 32'hDEADBEEF);
        chk("sw_m1_idle", {m1_rdata[0][30:0], m1_gnt[0] | m1_done[0]}, 32'd0);
        issue(0, 1, 1'b0, 12'h000, 32'h0, OP_W, 32'hDEADBEEF);
        chk("lw_m0_rdata_held", m0_rdata[0], 32'h0);

        // Contested loads: round-robin then fixed priority
        both_test(0);
        both_test(1);

        // Reset pulsed in the middle of a port 1 SB access
        set_port(0, 1, 1'b1, 1'b1, 12'h001, 32'h000000AA, OP_B);
        wait_gnt(0, 1);
        chk("sb_memwr_before_rst", {31'd0, mem_MemWr[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("sb_memwr_async_drop", {31'd0, mem_MemWr[0]}, 32'd0);
        chk("sb_rst_outputs",
            {17'd0, mem_Addr[0][7:0], mem_MemOp[0], m0_gnt[0], m1_gnt[0], m0_done[0], m1_done[0]}, 32'd0);
        chk("sb_rst_rdata", m0_rdata[0] | m1_rdata[0] | mem_DataIn[0], 32'd0);
        drop_req(0, 1);
        #2;
        rst = 1'b0;
        held[0] = 32'h0;
        held[1] = 32'h0;
        @(negedge clk);
        chk("sb_no_done", {30'd0, m1_done[0], m0_done[0]}, 32'd0);
        issue(0, 1, 1'b0, 12'h000, 32'h0, OP_W, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("gq_empty[%0d]", d), 32'(gq[d].size()), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sb_empty[%0d]", i), 32'(sb_q[i].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
